code_lock: RTL and testbench



---
 rtl/code_lock_pkg.sv | 25 ++
 rtl/code_lock_nibble_cmp.sv | 25 ++
 rtl/code_lock.sv | 220 ++++++++++++++++++++++
 tb/tb_code_lock.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// code_lock_pkg
// Shared types and constants for the code_lock combination lock.
//   state_t     : lock FSM state encoding (ENTRY/OPEN/PROG/LOCKOUT)
//   DIGIT_W     : width of one keypad digit (nibble)
//   IDX_W       : width of the digit index / progress counter
//   TIMER_W     : width of the lockout down-counter
//   FAILS_W     : width of the consecutive-failure counter
//   RESET_DIGIT : value every stored code digit takes after reset
package code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    PROG    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int IDX_W   = 3;
  localparam int TIMER_W = 8;
  localparam int FAILS_W = 2;

  localparam logic [DIGIT_W-1:0] RESET_DIGIT = 4'h0;

endpackage

// File: rtl/code_lock_nibble_cmp.sv
// nibble_cmp
// Combinational 4-bit equality: bitwise XNOR followed by an AND reduction.
// Ports:
//   a, b : nibbles to compare
//   eq   : 1 when a == b
module nibble_cmp
  import code_lock_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               eq
);

  logic [DIGIT_W-1:0] bit_same;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT_W; gi++) begin : g_xnor
      assign bit_same[gi] = ~(a[gi] ^ b[gi]);
    end
  endgenerate

  assign eq = &bit_same;

endmodule

// File: rtl/code_lock.sv
// code_lock
// Keypad-style combination lock. Digits are streamed in one per strobe and
// compared against a stored code; a full attempt of DIGITS digits is always
// consumed before a verdict. Consecutive failures lead to a timed lockout.
// While unlocked the code can be reprogrammed through a shadow buffer that
// is committed only when the last digit arrives.
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous, active-high reset
//   digit_in    : entered digit, sampled when digit_valid=1
//   digit_valid : one-cycle strobe, one digit per high cycle
//   load        : enter program mode (honoured only in OPEN)
//   relock      : return to ENTRY from OPEN or PROG (beats load)
//   unlocked    : high in OPEN or PROG
//   error       : one-cycle pulse after each failed attempt
//   locked_out  : high while in LOCKOUT
//   prog_mode   : high while in PROG
//   progress    : digits accepted in the current attempt / programming pass
module code_lock
  import code_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               load,
  input  logic               relock,
  output logic               unlocked,
  output logic               error,
  output logic               locked_out,
  output logic               prog_mode,
  output logic [IDX_W-1:0]   progress
);

  localparam int CODE_W = DIGITS * DIGIT_W;

  // Code and shadow are kept as flat vectors, digit i in bits [4i+3:4i].
  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [FAILS_W-1:0]   fails_reg, fails_next;
  logic                 mismatch_reg, mismatch_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [CODE_W-1:0]    code_reg, code_next;
  logic [CODE_W-1:0]    shadow_reg, shadow_next;

  logic                 unlocked_reg, unlocked_next;
  logic                 error_reg, error_next;
  logic                 locked_out_reg, locked_out_next;
  logic                 prog_mode_reg, prog_mode_next;
  logic [IDX_W-1:0]     progress_reg, progress_next;

  logic [DIGIT_W-1:0]   code_digit;
  logic                 digit_eq;
  logic                 last_digit;
  logic                 final_mismatch;
  logic                 fail_event;
  logic [CODE_W-1:0]    shadow_with_digit;

  // Select the stored digit that the current position must match.
  always_comb begin
    code_digit = RESET_DIGIT;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        code_digit = code_reg[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  nibble_cmp u_cmp (
    .a  (code_digit),
    .b  (digit_in),
    .eq (digit_eq)
  );

  // Shadow buffer with the incoming digit already written at idx, so the
  // final programming digit lands in the code in the same edge.
  always_comb begin
    shadow_with_digit = shadow_reg;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        shadow_with_digit[i*DIGIT_W +: DIGIT_W] = digit_in;
      end
    end
  end

  assign last_digit     = (idx_reg == IDX_W'(DIGITS - 1));
  assign final_mismatch = mismatch_reg | ~digit_eq;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ENTRY;
      idx_reg        <= '0;
      fails_reg      <= '0;
      mismatch_reg   <= 1'b0;
      timer_reg      <= '0;
      code_reg       <= {DIGITS{RESET_DIGIT}};
      shadow_reg     <= {DIGITS{RESET_DIGIT}};
      unlocked_reg   <= 1'b0;
      error_reg      <= 1'b0;
      locked_out_reg <= 1'b0;
      prog_mode_reg  <= 1'b0;
      progress_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      fails_reg      <= fails_next;
      mismatch_reg   <= mismatch_next;
      timer_reg      <= timer_next;
      code_reg       <= code_next;
      shadow_reg     <= shadow_next;
      unlocked_reg   <= unlocked_next;
      error_reg      <= error_next;
      locked_out_reg <= locked_out_next;
      prog_mode_reg  <= prog_mode_next;
      progress_reg   <= progress_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    fails_next    = fails_reg;
    mismatch_next = mismatch_reg;
    timer_next    = timer_reg;
    code_next     = code_reg;
    shadow_next   = shadow_reg;
    fail_event    = 1'b0;

    unique case (state_reg)
      ENTRY: begin
        if (digit_valid) begin
          if (last_digit) begin
            idx_next      = '0;
            mismatch_next = 1'b0;
            if (!final_mismatch) begin
              state_next = OPEN;
              fails_next = '0;
            end else begin
              fail_event = 1'b1;
              if (fails_reg + FAILS_W'(1) == FAILS_W'(MAX_FAILS)) begin
                state_next = LOCKOUT;
                timer_next = TIMER_W'(LOCKOUT_CYCLES);
              end else begin
                fails_next = fails_reg + FAILS_W'(1);
              end
            end
          end else begin
            idx_next      = idx_reg + IDX_W'(1);
            mismatch_next = final_mismatch;
          end
        end
      end

      OPEN: begin
        if (relock) begin
          state_next = ENTRY;
          idx_next   = '0;
        end else if (load) begin
          state_next = PROG;
          idx_next   = '0;
        end
      end

      PROG: begin
        // relock abandons the pass, even alongside the final digit.
        if (relock) begin
          state_next = ENTRY;
          idx_next   = '0;
        end else if (digit_valid) begin
          shadow_next = shadow_with_digit;
          if (last_digit) begin
            code_next  = shadow_with_digit;
            state_next = OPEN;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end

      LOCKOUT: begin
        timer_next = timer_reg - TIMER_W'(1);
        if (timer_reg == TIMER_W'(1)) begin
          state_next = ENTRY;
          fails_next = '0;
        end
      end

      default: begin
        state_next = ENTRY;
        idx_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    unlocked_next   = (state_next == OPEN) || (state_next == PROG);
    locked_out_next = (state_next == LOCKOUT);
    prog_mode_next  = (state_next == PROG);
    error_next      = fail_event;
    progress_next   = '0;
    if ((state_next == ENTRY) || (state_next == PROG)) begin
      progress_next = idx_next;
    end
  end

  assign unlocked   = unlocked_reg;
  assign error      = error_reg;
  assign locked_out = locked_out_reg;
  assign prog_mode  = prog_mode_reg;
  assign progress   = progress_reg;

endmodule

// File: tb/tb_code_lock.sv
module tb_code_lock;

  localparam int DIGITS         = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;

  logic       clk;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       load;
  logic       relock;
  logic       unlocked;
  logic       error;
  logic       locked_out;
  logic       prog_mode;
  logic [2:0] progress;

  code_lock #(
    .DIGITS         (DIGITS),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .load        (load),
    .relock      (relock),
    .unlocked    (unlocked),
    .error       (error),
    .locked_out  (locked_out),
    .prog_mode   (prog_mode),
    .progress    (progress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unlocked;
    int error;
    int locked_out;
    int prog_mode;
    int progress;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;
  bit   stim_done = 0;

  // Reference model: attempts are collected as whole digit lists and
  // compared against the code list once complete.
  int m_code[DIGITS];
  int m_entered[$];
  int m_progbuf[$];
  bit m_open;
  bit m_prog;
  int m_lock_left;
  int m_fails;
  bit m_err;

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) m_code[i] = 0;
    m_entered   = {};
    m_progbuf   = {};
    m_open      = 0;
    m_prog      = 0;
    m_lock_left = 0;
    m_fails     = 0;
    m_err       = 0;
  endtask

  task automatic model_step(input bit rst, input bit dv, input int d,
                            input bit ld, input bit rl);
    bit ok;
    m_err = 0;
    if (rst) begin
      model_reset();
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_prog) begin
      if (rl) begin
        m_prog    = 0;
        m_open    = 0;
        m_progbuf = {};
      end else if (dv) begin
        m_progbuf.push_back(d);
        if (m_progbuf.size() == DIGITS) begin
          for (int i = 0; i < DIGITS; i++) m_code[i] = m_progbuf[i];
          m_progbuf = {};
          m_prog    = 0;
        end
      end
    end else if (m_open) begin
      if (rl) begin
        m_open = 0;
      end else if (ld) begin
        m_prog    = 1;
        m_progbuf = {};
      end
    end else if (dv) begin
      m_entered.push_back(d);
      if (m_entered.size() == DIGITS) begin
        ok = 1;
        for (int i = 0; i < DIGITS; i++)
          if (m_entered[i] != m_code[i]) ok = 0;
        m_entered = {};
        if (ok) begin
          m_open  = 1;
          m_fails = 0;
        end else begin
          m_err = 1;
          if (m_fails + 1 == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
          else m_fails++;
        end
      end
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.unlocked   = int'(m_open || m_prog);
    e.error      = int'(m_err);
    e.locked_out = int'(m_lock_left > 0);
    e.prog_mode  = int'(m_prog);
    if (m_prog)                            e.progress = m_progbuf.size();
    else if (!m_open && m_lock_left == 0)  e.progress = m_entered.size();
    else                                   e.progress = 0;
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the response
  // to the next rising edge and queue it for the monitor.
  task automatic cyc(input bit rst, input bit dv, input int d,
                     input bit ld, input bit rl);
    @(negedge clk);
    reset       = rst;
    digit_valid = dv;
    digit_in    = 4'(d);
    load        = ld;
    relock      = rl;
    model_step(rst, dv, d, ld, rl);
    exp_q.push_back(model_outputs());
    if (rst || dv || ld || rl) begin
      txn++;
      $display("txn %0d: reset=%0d digit_valid=%0d digit=%h load=%0d relock=%0d",
               txn, rst, dv, d, ld, rl);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic enter(input logic [15:0] word);
    logic [15:0] w;
    w = word;
    for (int i = 0; i < DIGITS; i++) begin
      cyc(0, 1, int'(w[15-4*i -: 4]), 0, 0);
      idle(1);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising edge with a queued prediction is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("unlocked",   int'(unlocked),   e.unlocked);
        chk("error",      int'(error),      e.error);
        chk("locked_out", int'(locked_out), e.locked_out);
        chk("prog_mode",  int'(prog_mode),  e.prog_mode);
        chk("progress",   int'(progress),   e.progress);
      end
    end
  end

  initial begin
    bit dv, ld, rl, rst;
    int d;
    reset = 1'b1; digit_valid = 1'b0; digit_in = 4'h0; load = 1'b0; relock = 1'b0;
    model_reset();

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);

    // Default code 0000 unlocks.
    enter(16'h0000);
    idle(2);
    // Reprogram to A53C, relock, unlock with the new code.
    cyc(0, 0, 0, 1, 0);
    enter(16'hA53C);
    cyc(0, 0, 0, 0, 1);
    enter(16'hA53C);
    cyc(0, 0, 0, 0, 1);
    // Old code now fails; single wrong digit fails too.
    enter(16'h0000);
    enter(16'hA03C);
    // Third failure in a row locks out; digits during lockout are ignored.
    enter(16'h1111);
    enter(16'hA53C);
    enter(16'hA53C);
    idle(10);
    enter(16'hA53C);
    // Relock together with the final programming strobe commits nothing.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 2, 0, 0);
    cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 4, 0, 1);
    enter(16'h1234);
    enter(16'hA53C);
    // Reset mid-PROG, then mid-LOCKOUT.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 0);
    enter(16'h0000);
    cyc(0, 0, 0, 0, 1);
    enter(16'h0001);
    enter(16'h0002);
    enter(16'h0003);
    idle(5);
    cyc(1, 0, 0, 0, 0);
    enter(16'h0000);
    cyc(0, 0, 0, 0, 1);

    // Randomized phase; digits biased toward the stored code.
    for (int n = 0; n < 400; n++) begin
      dv  = ($urandom_range(0, 1) == 1);
      ld  = ($urandom_range(0, 7) == 0);
      rl  = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if (!m_prog && !m_open && m_lock_left == 0 && $urandom_range(0, 3) != 0)
        d = m_code[m_entered.size()];
      else
        d = int'($urandom_range(0, 15));
      cyc(rst, dv, d, ld, rl);
    end

    idle(3);
    stim_done = 1;
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    if (!stim_done) begin
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
